// File: rtl/lsu_dcfill_pkg.sv
// Shared types for the D$ fill write-request queue: entry layout, FSM encoding, sizes.
package lsu_dcfill_pkg;

    localparam int DC_WDATA_W = 144;

    typedef struct packed {
        logic [7:0]   addr;
        logic [127:0] data;
        logic [15:0]  par;
        logic [3:0]   way;
        logic [15:0]  byte_en;
    } wrq_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DEFER = 2'd2,
        FORCE = 2'd3
    } wrq_state_t;

    function automatic logic [3:0] sat_inc(input logic [3:0] cnt, input logic [3:0] max);
        return (cnt >= max) ? cnt : cnt + 4'd1;
    endfunction

endpackage

// File: rtl/lsu_dcfill_par16.sv
// Byte-wise parity generator: par[i] is the XOR of data byte i.
module lsu_dcfill_par16 (
    input  logic [127:0] data,
    output logic [15:0]  par
);

    // NOTE: combinational blocks use blocking '=' and assign a default first, so no latch is inferred.
    always_comb begin
        par = '0;
        for (int i = 0; i < 16; i++) begin
            par[i] = ^data[8*i +: 8];
        end
    end

endmodule

// File: rtl/lsu_dcfill_wrq.sv
// Write-request queue in front of the D$ data array; reads win, an anti-starvation FSM forces a write slot.
// Optional macro LSU_DCFILL_PAR_INJ_EN adds wrq_par_inj to invert stored parity bit 0.
module lsu_dcfill_wrq
    import lsu_dcfill_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int MAX_DEFER = 7
) (
    input  logic                  rclk,
    input  logic                  arst_l,
    input  logic                  wrq_in_vld,
    output logic                  wrq_in_rdy,
    input  logic [7:0]            wrq_in_addr,
    input  logic [127:0]          wrq_in_data,
    input  logic [3:0]            wrq_in_way,
    input  logic [15:0]           wrq_in_byte_en,
    input  logic                  dcache_rvld_e,
    output logic                  dcache_wvld_e,
    output logic [7:0]            dcache_alt_addr_e,
    output logic [DC_WDATA_W-1:0] dcache_wdata_e,
    output logic [3:0]            dcache_wr_rway_e,
    output logic [15:0]           dcache_byte_wr_en_e,
    output logic                  wrq_rd_stall,
    output logic                  wrq_empty
`ifdef LSU_DCFILL_PAR_INJ_EN
    ,
    input  logic                  wrq_par_inj
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [3:0] MAX_D = 4'(MAX_DEFER);

    wrq_entry_t       mem [DEPTH];
    wrq_entry_t       new_entry;
    wrq_entry_t       head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic [15:0]      par_gen;
    logic [15:0]      par_st;
    logic [3:0]       defer_cnt;
    logic [3:0]       defer_inc;
    wrq_state_t       state;
    logic             push;
    logic             pop;

    lsu_dcfill_par16 u_par (
        .data (wrq_in_data),
        .par  (par_gen)
    );

`ifdef LSU_DCFILL_PAR_INJ_EN
    assign par_st = par_gen ^ {15'b0, wrq_par_inj};
`else
    assign par_st = par_gen;
`endif

    assign new_entry = '{addr: wrq_in_addr, data: wrq_in_data, par: par_st,
                         way: wrq_in_way, byte_en: wrq_in_byte_en};

    assign wrq_in_rdy    = (count != CNT_W'(DEPTH));
    assign wrq_empty     = (count == '0);
    assign dcache_wvld_e = !wrq_empty && !dcache_rvld_e;
    assign push          = wrq_in_vld && wrq_in_rdy;
    assign pop           = dcache_wvld_e;
    assign count_nxt     = count + CNT_W'(push) - CNT_W'(pop);
    assign defer_inc     = sat_inc(defer_cnt, MAX_D);

    // Head fields are masked while empty so stale storage never reaches the array port.
    assign head                = mem[rd_ptr];
    assign dcache_alt_addr_e   = wrq_empty ? '0 : head.addr;
    assign dcache_wdata_e      = wrq_empty ? '0 : {head.par, head.data};
    assign dcache_wr_rway_e    = wrq_empty ? '0 : head.way;
    assign dcache_byte_wr_en_e = wrq_empty ? '0 : head.byte_en;

    // NOTE: the entry storage has no reset; validity comes from count, which is reset.
    always_ff @(posedge rclk) begin
        if (push) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
        end
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            state        <= IDLE;
            defer_cnt    <= '0;
            wrq_rd_stall <= 1'b0;
        end else if (count_nxt == '0) begin
            state        <= IDLE;
            defer_cnt    <= '0;
            wrq_rd_stall <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (push) state <= ISSUE;
                end
                default: begin
                    if (pop) begin
                        state        <= ISSUE;
                        defer_cnt    <= '0;
                        wrq_rd_stall <= 1'b0;
                    end else begin
                        // Blocked by a read: count it and force a stall once the budget is spent.
                        defer_cnt <= defer_inc;
                        if (defer_inc == MAX_D) begin
                            state        <= FORCE;
                            wrq_rd_stall <= 1'b1;
                        end else begin
                            state        <= DEFER;
                            wrq_rd_stall <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule
